// File: rtl/map_cell_loader.sv
`default_nettype none
// ============================================================================
// Module   : map_cell_loader
// Purpose  : Parses host-link packets (SYNC, CMD, X, Y, DATA) into cell-write,
//            commit and clear-all commands for the frame-buffer map stage.
//            Every map write is a SETUP / STROBE / HOLD sequence, so the
//            coordinates and data are stable around the toggle pulse.
// Options  : MAP_LOADER_CHECKSUM_EN adds a CSUM byte (CMD^X^Y^DATA) after DATA.
// Revision : 1.0 - initial release
// ============================================================================
module map_cell_loader #(
   parameter int unsigned GRID_W      = 14,
   parameter int unsigned GRID_H      = 8,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] x,
   output logic [7:0] y,
   output logic [7:0] dataOut,
   output logic       toggle,
   output logic       switchBuffer,
   output logic       commit,
   output logic [7:0] err_cnt
);

   localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0] X_LAST    = 8'(GRID_W - 1);
   localparam logic [7:0] Y_LAST    = 8'(GRID_H - 1);
   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_COMMIT = 8'h02;
   localparam logic [7:0] CMD_CLEAR  = 8'h03;

   typedef enum logic [3:0] {
      S_IDLE,
      S_GET_CMD,
      S_GET_X,
      S_GET_Y,
      S_GET_DATA,
`ifdef MAP_LOADER_CHECKSUM_EN
      S_GET_CSUM,
`endif
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_CLEAR
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      sx_q, sx_d;
   logic [7:0]      sy_q, sy_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      x_q, x_d;
   logic [7:0]      y_q, y_d;
   logic [7:0]      data_q, data_d;
   logic            toggle_q, toggle_d;
   logic            sb_q, sb_d;
   logic            commit_q, commit_d;
   logic [7:0]      err_q, err_d;
   logic            clr_q, clr_d;

   logic            w_in_get;
   logic            w_xfer;
   logic            w_validate;
   logic            w_pkt_ok;
   logic [7:0]      w_fin_data;
   logic [7:0]      w_err_inc;

   // The validating byte (DATA, or CSUM when enabled) is checked on the very
   // edge it is accepted so that the strobe lands two cycles after it.
`ifdef MAP_LOADER_CHECKSUM_EN
   logic [7:0]      sd_q, sd_d;
   logic            w_csum_ok;
   assign w_fin_data = sd_q;
   assign w_csum_ok  = (byte_in == (cmd_q ^ sx_q ^ sy_q ^ sd_q));
   assign w_validate = w_xfer && (state_q == S_GET_CSUM);
   assign w_in_get   = (state_q == S_GET_CMD) || (state_q == S_GET_X) ||
                       (state_q == S_GET_Y)   || (state_q == S_GET_DATA) ||
                       (state_q == S_GET_CSUM);
`else
   assign w_fin_data = byte_in;
   assign w_validate = w_xfer && (state_q == S_GET_DATA);
   assign w_in_get   = (state_q == S_GET_CMD) || (state_q == S_GET_X) ||
                       (state_q == S_GET_Y)   || (state_q == S_GET_DATA);
`endif

   assign byte_ready = (state_q == S_IDLE) || w_in_get;
   assign w_xfer     = byte_valid && byte_ready;
   assign w_err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

   always_comb begin
      w_pkt_ok = (cmd_q == CMD_WRITE) || (cmd_q == CMD_COMMIT) || (cmd_q == CMD_CLEAR);
      if (cmd_q == CMD_WRITE && ((32'(sx_q) >= GRID_W) || (32'(sy_q) >= GRID_H)))
         w_pkt_ok = 1'b0;
`ifdef MAP_LOADER_CHECKSUM_EN
      if (!w_csum_ok)
         w_pkt_ok = 1'b0;
`endif
   end

   // Next-state logic: packet parsing, validation, timeout and write sequencing
   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      tmo_d    = tmo_q;
      x_d      = x_q;
      y_d      = y_q;
      data_d   = data_q;
      toggle_d = 1'b0;
      sb_d     = sb_q;
      commit_d = 1'b0;
      err_d    = err_q;
      clr_d    = clr_q;
`ifdef MAP_LOADER_CHECKSUM_EN
      sd_d     = sd_q;
`endif

      case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            if (w_xfer && byte_in == SYNC_BYTE) state_d = S_GET_CMD;
         end
         S_GET_CMD: if (w_xfer) begin cmd_d = byte_in; state_d = S_GET_X; end
         S_GET_X:   if (w_xfer) begin sx_d  = byte_in; state_d = S_GET_Y; end
         S_GET_Y:   if (w_xfer) begin sy_d  = byte_in; state_d = S_GET_DATA; end
         S_GET_DATA: begin
`ifdef MAP_LOADER_CHECKSUM_EN
            if (w_xfer) begin sd_d = byte_in; state_d = S_GET_CSUM; end
`endif
         end
`ifdef MAP_LOADER_CHECKSUM_EN
         S_GET_CSUM: begin end
`endif
         S_SETUP, S_CLEAR: begin
            toggle_d = 1'b1;
            state_d  = S_STROBE;
         end
         S_STROBE: state_d = S_HOLD;
         S_HOLD: begin
            if (clr_q && !(x_q == X_LAST && y_q == Y_LAST)) begin
               // Next cell of a clear: x runs fastest, write enable stays up
               if (x_q == X_LAST) begin
                  x_d = 8'd0;
                  y_d = y_q + 8'd1;
               end else begin
                  x_d = x_q + 8'd1;
               end
               state_d = S_CLEAR;
            end else begin
               sb_d    = 1'b0;
               clr_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Idle-gap watchdog while a packet is partially received
      if (w_in_get) begin
         if (w_xfer) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            tmo_d   = '0;
            err_d   = w_err_inc;
            state_d = S_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      if (w_validate) begin
         if (!w_pkt_ok) begin
            err_d   = w_err_inc;
            state_d = S_IDLE;
         end else if (cmd_q == CMD_WRITE) begin
            x_d     = sx_q;
            y_d     = sy_q;
            data_d  = w_fin_data;
            sb_d    = 1'b1;
            state_d = S_SETUP;
         end else if (cmd_q == CMD_COMMIT) begin
            commit_d = 1'b1;
            state_d  = S_IDLE;
         end else begin
            x_d     = 8'd0;
            y_d     = 8'd0;
            data_d  = 8'd0;
            sb_d    = 1'b1;
            clr_d   = 1'b1;
            state_d = S_CLEAR;
         end
      end
   end

   // State and registered outputs; reset abandons any clear in progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cmd_q    <= 8'd0;
         sx_q     <= 8'd0;
         sy_q     <= 8'd0;
         tmo_q    <= '0;
         x_q      <= 8'd0;
         y_q      <= 8'd0;
         data_q   <= 8'd0;
         toggle_q <= 1'b0;
         sb_q     <= 1'b0;
         commit_q <= 1'b0;
         err_q    <= 8'd0;
         clr_q    <= 1'b0;
`ifdef MAP_LOADER_CHECKSUM_EN
         sd_q     <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         tmo_q    <= tmo_d;
         x_q      <= x_d;
         y_q      <= y_d;
         data_q   <= data_d;
         toggle_q <= toggle_d;
         sb_q     <= sb_d;
         commit_q <= commit_d;
         err_q    <= err_d;
         clr_q    <= clr_d;
`ifdef MAP_LOADER_CHECKSUM_EN
         sd_q     <= sd_d;
`endif
      end
   end

   assign x            = x_q;
   assign y            = y_q;
   assign dataOut      = data_q;
   assign toggle       = toggle_q;
   assign switchBuffer = sb_q;
   assign commit       = commit_q;
   assign err_cnt      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_map_cell_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_cell_loader
// Purpose  : Directed self-checking bench for map_cell_loader (write, commit,
//            drop, clear-all, reset mid-clear, timeout, optional checksum).
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_cell_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] byte_in = 8'd0;
   logic       byte_valid = 1'b0;
   logic       byte_ready;
   logic [7:0] x, y, dataOut, err_cnt;
   logic       toggle, switchBuffer, commit;

   int n_cmp = 0;
   int n_bad = 0;
   int n_tog = 0;
   int n_viol = 0;
   logic prev_sb = 1'b0;
   logic prev_tog = 1'b0;

   map_cell_loader #(
      .GRID_W(14), .GRID_H(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(20)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .x(x), .y(y), .dataOut(dataOut),
      .toggle(toggle), .switchBuffer(switchBuffer), .commit(commit),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Strobe bookkeeping: pulse count plus enable-before-strobe and one-cycle rules
   always @(negedge clk) begin
      if (toggle) n_tog++;
      if (toggle && (!prev_sb || prev_tog)) n_viol++;
      prev_sb  = switchBuffer;
      prev_tog = toggle;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      while (!byte_ready && waited < 500) begin
         tick();
         waited++;
      end
      if (!byte_ready) chk("ready_wait", {31'd0, byte_ready}, 32'd1);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] c, input logic [7:0] px,
                           input logic [7:0] py, input logic [7:0] d);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(px);
      send_byte(py);
      send_byte(d);
`ifdef MAP_LOADER_CHECKSUM_EN
      send_byte(c ^ px ^ py ^ d);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      int busy_ready;
      int pulses;
      logic [7:0] ex, ey;

      // Reset values
      repeat (3) tick();
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_data", dataOut, 0);
      chk("rst_toggle", toggle, 0);
      chk("rst_sb", switchBuffer, 0);
      chk("rst_commit", commit, 0);
      chk("rst_err", err_cnt, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready", byte_ready, 1);

      // Cell write (3,2)=1: SETUP, STROBE, HOLD, back to IDLE
      send_pkt(8'h01, 8'h03, 8'h02, 8'h01);
      chk("wr_setup_sb", switchBuffer, 1);
      chk("wr_setup_tog", toggle, 0);
      chk("wr_x", x, 3);
      chk("wr_y", y, 2);
      chk("wr_data", dataOut, 1);
      chk("wr_ready_busy", byte_ready, 0);
      tick();
      chk("wr_strobe_tog", toggle, 1);
      chk("wr_strobe_sb", switchBuffer, 1);
      tick();
      chk("wr_hold_tog", toggle, 0);
      chk("wr_hold_sb", switchBuffer, 1);
      tick();
      chk("wr_idle_sb", switchBuffer, 0);
      chk("wr_idle_ready", byte_ready, 1);
      chk("wr_keep_x", x, 3);
      chk("wr_err", err_cnt, 0);

      // Leading junk then commit
      t0 = n_tog;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_pkt(8'h02, 8'h00, 8'h00, 8'h00);
      chk("cm_pulse", commit, 1);
      chk("cm_sb", switchBuffer, 0);
      tick();
      chk("cm_low1", commit, 0);
      tick();
      chk("cm_low2", commit, 0);
      chk("cm_no_tog", n_tog - t0, 0);
      chk("cm_err", err_cnt, 0);

      // Dropped packets: x out of range, bad command, y out of range
      t0 = n_tog;
      send_pkt(8'h01, 8'h0E, 8'h00, 8'h01);
      chk("dx_sb", switchBuffer, 0);
      chk("dx_err", err_cnt, 1);
      send_pkt(8'h07, 8'h00, 8'h00, 8'h00);
      chk("dc_err", err_cnt, 2);
      chk("dc_commit", commit, 0);
      send_pkt(8'h01, 8'h00, 8'h08, 8'h00);
      chk("dy_err", err_cnt, 3);
      repeat (3) tick();
      chk("drop_no_tog", n_tog - t0, 0);

      // Clear all: 112 strobes over 336 cycles, x fastest
      send_pkt(8'h03, 8'h00, 8'h00, 8'h00);
      busy_ready = 0;
      pulses = 0;
      ex = 8'd0;
      ey = 8'd0;
      for (int c = 0; c < 336; c++) begin
         if (byte_ready) busy_ready++;
         if (toggle) begin
            pulses++;
            chk("clr_x", x, ex);
            chk("clr_y", y, ey);
            chk("clr_data", dataOut, 0);
            if (ex == 8'd13) begin
               ex = 8'd0;
               ey = ey + 8'd1;
            end else begin
               ex = ex + 8'd1;
            end
         end
         tick();
      end
      chk("clr_pulses", pulses, 112);
      chk("clr_busy_ready", busy_ready, 0);
      chk("clr_done_ready", byte_ready, 1);
      chk("clr_done_sb", switchBuffer, 0);

      // Reset in the middle of a clear
      send_pkt(8'h03, 8'h00, 8'h00, 8'h00);
      repeat (99) tick();
      rst_n = 1'b0;
      tick();
      chk("mr_x", x, 0);
      chk("mr_y", y, 0);
      chk("mr_toggle", toggle, 0);
      chk("mr_sb", switchBuffer, 0);
      chk("mr_err", err_cnt, 0);
      rst_n = 1'b1;
      t0 = n_tog;
      repeat (10) tick();
      chk("mr_ready", byte_ready, 1);
      chk("mr_no_resume", n_tog - t0, 0);
      send_pkt(8'h01, 8'h0D, 8'h07, 8'h01);
      chk("mr_wr_sb", switchBuffer, 1);
      chk("mr_wr_x", x, 13);
      chk("mr_wr_y", y, 7);
      tick();
      chk("mr_wr_tog", toggle, 1);
      repeat (2) tick();

      // Mid-packet timeout (TIMEOUT_CYC = 20)
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h05);
      repeat (19) tick();
      chk("to_before", err_cnt, 0);
      tick();
      chk("to_after", err_cnt, 1);
      chk("to_ready", byte_ready, 1);
      send_pkt(8'h01, 8'h05, 8'h04, 8'h01);
      chk("to_wr_x", x, 5);
      chk("to_wr_y", y, 4);
      tick();
      chk("to_wr_tog", toggle, 1);
      repeat (2) tick();

`ifdef MAP_LOADER_CHECKSUM_EN
      // Raw 6-byte packets: good and bad checksum
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h02); send_byte(8'h01); send_byte(8'h01);
      chk("cs_ok_sb", switchBuffer, 1);
      tick();
      chk("cs_ok_tog", toggle, 1);
      repeat (2) tick();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
      send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
      chk("cs_bad_sb", switchBuffer, 0);
      chk("cs_bad_err", err_cnt, 2);
`endif

      repeat (3) tick();
      chk("strobe_rules", n_viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
